// File: rtl/keypad_pkg.sv
// Shared types, constants and sizing helper for the matrix-keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    DWELL  = 2'd0,
    UPDATE = 2'd1,
    EMIT   = 2'd2
  } scan_state_e;

  localparam int DB_CNT_W = 4;

  // Index width for N items; never collapses to zero for a single item.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keypad_debounce_cell.sv
// Per-key debounce: counts consecutive disagreeing samples and flips the
// stored state after DEBOUNCE of them; flip is asserted in the flipping cycle.
module keypad_debounce_cell
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  input  logic enable,
  input  logic clear,
  output logic state,
  output logic flip
);

  logic [DB_CNT_W-1:0] cnt_reg, cnt_next;
  logic                state_reg, state_next;

  always_comb begin
    cnt_next   = cnt_reg;
    state_next = state_reg;
    flip       = 1'b0;
    if (enable) begin
      if (clear || (sample == state_reg)) begin
        cnt_next = '0;
      end else if (cnt_reg == DB_CNT_W'(DEBOUNCE - 1)) begin
        state_next = sample;
        cnt_next   = '0;
        flip       = 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      state_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Row/column keypad scanner: drives one row low at a time, debounces every key,
// and emits press/release events over valid/ready. Define KEYPAD_GHOST_FILTER_EN to reject ghost presses.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int N_ROWS   = 4,
  parameter int N_COLS   = 4,
  parameter int SCAN_DIV = 25000,
  parameter int DEBOUNCE = 4
) (
  input  logic                                CLK_25MHZ,
  input  logic                                RESET_N,
  output logic [N_ROWS-1:0]                   ROWS_OE,
  input  logic [N_COLS-1:0]                   COLS,
  output logic [N_ROWS*N_COLS-1:0]            KEYS,
  output logic                                EVT_VALID,
  input  logic                                EVT_READY,
  output logic [idx_w(N_ROWS*N_COLS)-1:0]     EVT_KEY,
  output logic                                EVT_PRESSED
);

  localparam int N_KEYS  = N_ROWS * N_COLS;
  localparam int KEY_W   = idx_w(N_KEYS);
  localparam int ROW_W   = idx_w(N_ROWS);
  localparam int COL_W   = idx_w(N_COLS);
  localparam int PRESC_W = idx_w(SCAN_DIV);

  scan_state_e         state_reg, state_next;
  logic [PRESC_W-1:0]  presc_reg, presc_next;
  logic [ROW_W-1:0]    row_reg, row_next;
  logic [COL_W-1:0]    col_reg, col_next;
  logic [N_ROWS-1:0]   rows_oe_reg, rows_oe_next;
  logic                evt_valid_reg, evt_valid_next;
  logic [KEY_W-1:0]    evt_key_reg, evt_key_next;
  logic                evt_pressed_reg, evt_pressed_next;
  logic [N_COLS-1:0]   cols_meta_reg, cols_sync_reg;
  logic [N_COLS-1:0]   raw_row;
  logic [N_KEYS-1:0]   flip_vec;
  logic [KEY_W-1:0]    key_sel;
  logic                cur_sample;
  logic                ghost_amb;
  logic                latch_row;
  logic                advance;

  assign key_sel    = KEY_W'(32'(row_reg) * N_COLS + 32'(col_reg));
  assign cur_sample = raw_row[col_reg];

`ifdef KEYPAD_GHOST_FILTER_EN
  // Whole-frame snapshot so a press can be tested for a rectangle of closed contacts.
  logic [N_COLS-1:0] raw_reg [N_ROWS];
  logic              cur_key_state;

  always_ff @(posedge CLK_25MHZ) begin
    if (!RESET_N) begin
      for (int r = 0; r < N_ROWS; r++) raw_reg[r] <= '0;
    end else if (latch_row) begin
      raw_reg[row_reg] <= ~cols_sync_reg;
    end
  end

  assign raw_row       = raw_reg[row_reg];
  assign cur_key_state = KEYS[key_sel];

  always_comb begin
    ghost_amb = 1'b0;
    if (cur_sample && !cur_key_state) begin
      for (int r = 0; r < N_ROWS; r++) begin
        for (int c = 0; c < N_COLS; c++) begin
          if ((ROW_W'(r) != row_reg) && (COL_W'(c) != col_reg) &&
              raw_reg[row_reg][c] && raw_reg[r][col_reg] && raw_reg[r][c])
            ghost_amb = 1'b1;
        end
      end
    end
  end
`else
  logic [N_COLS-1:0] raw_row_reg;

  always_ff @(posedge CLK_25MHZ) begin
    if (!RESET_N) begin
      raw_row_reg <= '0;
    end else if (latch_row) begin
      raw_row_reg <= ~cols_sync_reg;
    end
  end

  assign raw_row   = raw_row_reg;
  assign ghost_amb = 1'b0;
`endif

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_cell
    keypad_debounce_cell #(
      .DEBOUNCE (DEBOUNCE)
    ) u_cell (
      .clk    (CLK_25MHZ),
      .rst_n  (RESET_N),
      .sample (cur_sample),
      .enable ((state_reg == UPDATE) && (key_sel == KEY_W'(gi))),
      .clear  (ghost_amb),
      .state  (KEYS[gi]),
      .flip   (flip_vec[gi])
    );
  end

  always_comb begin
    state_next       = state_reg;
    presc_next       = presc_reg;
    row_next         = row_reg;
    col_next         = col_reg;
    rows_oe_next     = rows_oe_reg;
    evt_valid_next   = evt_valid_reg;
    evt_key_next     = evt_key_reg;
    evt_pressed_next = evt_pressed_reg;
    latch_row        = 1'b0;
    advance          = 1'b0;

    case (state_reg)
      DWELL: begin
        if (presc_reg == PRESC_W'(SCAN_DIV - 1)) begin
          latch_row  = 1'b1;
          col_next   = '0;
          state_next = UPDATE;
        end else begin
          presc_next = presc_reg + 1'b1;
        end
      end
      UPDATE: begin
        if (|flip_vec) begin
          evt_valid_next   = 1'b1;
          evt_key_next     = key_sel;
          evt_pressed_next = cur_sample;
          state_next       = EMIT;
        end else begin
          advance = 1'b1;
        end
      end
      EMIT: begin
        // Scan stays frozen until the consumer takes the event.
        if (EVT_READY) begin
          evt_valid_next = 1'b0;
          advance        = 1'b1;
        end
      end
      default: state_next = DWELL;
    endcase

    if (advance) begin
      if (col_reg == COL_W'(N_COLS - 1)) begin
        col_next   = '0;
        presc_next = '0;
        state_next = DWELL;
        row_next   = (row_reg == ROW_W'(N_ROWS - 1)) ? '0 : row_reg + 1'b1;
        for (int r = 0; r < N_ROWS; r++) rows_oe_next[r] = (ROW_W'(r) == row_next);
      end else begin
        col_next   = col_reg + 1'b1;
        state_next = UPDATE;
      end
    end
  end

  always_ff @(posedge CLK_25MHZ) begin
    if (!RESET_N) begin
      state_reg       <= DWELL;
      presc_reg       <= '0;
      row_reg         <= '0;
      col_reg         <= '0;
      rows_oe_reg     <= N_ROWS'(1);
      evt_valid_reg   <= 1'b0;
      evt_key_reg     <= '0;
      evt_pressed_reg <= 1'b0;
      cols_meta_reg   <= '1;
      cols_sync_reg   <= '1;
    end else begin
      state_reg       <= state_next;
      presc_reg       <= presc_next;
      row_reg         <= row_next;
      col_reg         <= col_next;
      rows_oe_reg     <= rows_oe_next;
      evt_valid_reg   <= evt_valid_next;
      evt_key_reg     <= evt_key_next;
      evt_pressed_reg <= evt_pressed_next;
      cols_meta_reg   <= COLS;
      cols_sync_reg   <= cols_meta_reg;
    end
  end

  assign ROWS_OE     = rows_oe_reg;
  assign EVT_VALID   = evt_valid_reg;
  assign EVT_KEY     = evt_key_reg;
  assign EVT_PRESSED = evt_pressed_reg;

endmodule
